// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs
// Purpose  : Reservation station feeding the ALU. It holds arithmetic,
//            branch and JALR micro-ops until both source operands are known.
//            Operands are captured from the ALU and LSB result broadcasts.
//            It issues at most one ready entry per cycle through registered
//            outputs, and a branch mispredict flushes every entry.
// Ports    : clk, rst (sync, active-high), rdy (global stall when low),
//            jp_wrong (flush), dsp_* (dispatch request), rs_full (no free
//            entry), alu_cdb_* / lsb_cdb_* (result broadcasts),
//            ins_flag / insty / val1 / val2 / ROB_idx (issue to ALU).
// Options  : RS_OLDEST_FIRST_EN - when defined, each entry keeps a 4-bit
//            saturating age and issue picks the oldest eligible entry
//            (ties go to the lowest index). When undefined, issue picks
//            the lowest-index eligible entry.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rs #(
  parameter int RS_SIZE   = 16,
  parameter int ROB_IDX_W = 4,
  parameter int INSTY_W   = 6,
  parameter int XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 jp_wrong,
  input  logic                 dsp_flag,
  input  logic [INSTY_W-1:0]   dsp_insty,
  input  logic                 dsp_Q1_rdy,
  input  logic                 dsp_Q2_rdy,
  input  logic [XLEN-1:0]      dsp_V1,
  input  logic [XLEN-1:0]      dsp_V2,
  input  logic [ROB_IDX_W-1:0] dsp_Q1,
  input  logic [ROB_IDX_W-1:0] dsp_Q2,
  input  logic [ROB_IDX_W-1:0] dsp_ROB_idx,
  output logic                 rs_full,
  input  logic                 alu_cdb_flag,
  input  logic [ROB_IDX_W-1:0] alu_cdb_idx,
  input  logic [XLEN-1:0]      alu_cdb_val,
  input  logic                 lsb_cdb_flag,
  input  logic [ROB_IDX_W-1:0] lsb_cdb_idx,
  input  logic [XLEN-1:0]      lsb_cdb_val,
  output logic                 ins_flag,
  output logic [INSTY_W-1:0]   insty,
  output logic [XLEN-1:0]      val1,
  output logic [XLEN-1:0]      val2,
  output logic [ROB_IDX_W-1:0] ROB_idx
);

  localparam int IDX_W = $clog2(RS_SIZE);

  // Entry storage
  logic [RS_SIZE-1:0]   r_busy;
  logic [RS_SIZE-1:0]   r_q1_rdy;
  logic [RS_SIZE-1:0]   r_q2_rdy;
  logic [INSTY_W-1:0]   r_insty [RS_SIZE];
  logic [XLEN-1:0]      r_v1    [RS_SIZE];
  logic [XLEN-1:0]      r_v2    [RS_SIZE];
  logic [ROB_IDX_W-1:0] r_q1    [RS_SIZE];
  logic [ROB_IDX_W-1:0] r_q2    [RS_SIZE];
  logic [ROB_IDX_W-1:0] r_rob   [RS_SIZE];
`ifdef RS_OLDEST_FIRST_EN
  logic [3:0]           r_age   [RS_SIZE];
  logic [3:0]           w_best_age;
`endif

  logic [RS_SIZE-1:0]   w_elig;
  logic [IDX_W-1:0]     w_free_idx;
  logic [IDX_W-1:0]     w_iss_idx;
  logic                 w_iss_found;
  logic                 w_dsp_go;
  logic                 w_dsp_q1_rdy;
  logic                 w_dsp_q2_rdy;
  logic [XLEN-1:0]      w_dsp_v1;
  logic [XLEN-1:0]      w_dsp_v2;

  assign rs_full  = &r_busy;
  assign w_elig   = r_busy & r_q1_rdy & r_q2_rdy;
  assign w_dsp_go = dsp_flag && !rs_full;

  // Lowest-index free slot; scanning downward lets the lowest index win.
  always_comb begin
    w_free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_idx = IDX_W'(i);
      end
    end
  end

  // Issue selection works only on registered state, so an entry woken or
  // dispatched this cycle cannot be chosen before the next one.
`ifdef RS_OLDEST_FIRST_EN
  always_comb begin
    w_iss_idx   = '0;
    w_iss_found = 1'b0;
    w_best_age  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      // Strict greater-than keeps the lowest index on age ties.
      if (w_elig[i] && (!w_iss_found || (r_age[i] > w_best_age))) begin
        w_iss_idx   = IDX_W'(i);
        w_iss_found = 1'b1;
        w_best_age  = r_age[i];
      end
    end
  end
`else
  always_comb begin
    w_iss_idx   = '0;
    w_iss_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_iss_idx   = IDX_W'(i);
        w_iss_found = 1'b1;
      end
    end
  end
`endif

  // Same-cycle bypass for dispatched operands; the ALU broadcast wins if
  // both broadcasts (illegally) match.
  always_comb begin
    w_dsp_q1_rdy = dsp_Q1_rdy;
    w_dsp_v1     = dsp_V1;
    if (!dsp_Q1_rdy) begin
      if (alu_cdb_flag && (alu_cdb_idx == dsp_Q1)) begin
        w_dsp_q1_rdy = 1'b1;
        w_dsp_v1     = alu_cdb_val;
      end else if (lsb_cdb_flag && (lsb_cdb_idx == dsp_Q1)) begin
        w_dsp_q1_rdy = 1'b1;
        w_dsp_v1     = lsb_cdb_val;
      end
    end
    w_dsp_q2_rdy = dsp_Q2_rdy;
    w_dsp_v2     = dsp_V2;
    if (!dsp_Q2_rdy) begin
      if (alu_cdb_flag && (alu_cdb_idx == dsp_Q2)) begin
        w_dsp_q2_rdy = 1'b1;
        w_dsp_v2     = alu_cdb_val;
      end else if (lsb_cdb_flag && (lsb_cdb_idx == dsp_Q2)) begin
        w_dsp_q2_rdy = 1'b1;
        w_dsp_v2     = lsb_cdb_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= '0;
      ins_flag <= 1'b0;
      insty    <= '0;
      val1     <= '0;
      val2     <= '0;
      ROB_idx  <= '0;
`ifdef RS_OLDEST_FIRST_EN
      for (int i = 0; i < RS_SIZE; i++) r_age[i] <= '0;
`endif
    end else if (!rdy) begin
      // Entries are frozen; only the issue strobe drops so the ALU does
      // not see the last issued op a second time.
      ins_flag <= 1'b0;
    end else if (jp_wrong) begin
      r_busy   <= '0;
      ins_flag <= 1'b0;
      insty    <= '0;
      val1     <= '0;
      val2     <= '0;
      ROB_idx  <= '0;
`ifdef RS_OLDEST_FIRST_EN
      for (int i = 0; i < RS_SIZE; i++) r_age[i] <= '0;
`endif
    end else begin
      // Issue
      ins_flag <= w_iss_found;
      if (w_iss_found) begin
        insty             <= r_insty[w_iss_idx];
        val1              <= r_v1[w_iss_idx];
        val2              <= r_v2[w_iss_idx];
        ROB_idx           <= r_rob[w_iss_idx];
        r_busy[w_iss_idx] <= 1'b0;
      end else begin
        insty   <= '0;
        val1    <= '0;
        val2    <= '0;
        ROB_idx <= '0;
      end

      // Wakeup from both broadcasts
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i] && !r_q1_rdy[i]) begin
          if (alu_cdb_flag && (alu_cdb_idx == r_q1[i])) begin
            r_v1[i]     <= alu_cdb_val;
            r_q1_rdy[i] <= 1'b1;
          end else if (lsb_cdb_flag && (lsb_cdb_idx == r_q1[i])) begin
            r_v1[i]     <= lsb_cdb_val;
            r_q1_rdy[i] <= 1'b1;
          end
        end
        if (r_busy[i] && !r_q2_rdy[i]) begin
          if (alu_cdb_flag && (alu_cdb_idx == r_q2[i])) begin
            r_v2[i]     <= alu_cdb_val;
            r_q2_rdy[i] <= 1'b1;
          end else if (lsb_cdb_flag && (lsb_cdb_idx == r_q2[i])) begin
            r_v2[i]     <= lsb_cdb_val;
            r_q2_rdy[i] <= 1'b1;
          end
        end
`ifdef RS_OLDEST_FIRST_EN
        if (r_busy[i] && (r_age[i] != 4'hF)) begin
          r_age[i] <= r_age[i] + 4'd1;
        end
`endif
      end

      // Dispatch into a slot that is free at the start of the cycle, so it
      // never collides with the issued or woken entries above.
      if (w_dsp_go) begin
        r_busy[w_free_idx]   <= 1'b1;
        r_insty[w_free_idx]  <= dsp_insty;
        r_v1[w_free_idx]     <= w_dsp_v1;
        r_v2[w_free_idx]     <= w_dsp_v2;
        r_q1[w_free_idx]     <= dsp_Q1;
        r_q2[w_free_idx]     <= dsp_Q2;
        r_q1_rdy[w_free_idx] <= w_dsp_q1_rdy;
        r_q2_rdy[w_free_idx] <= w_dsp_q2_rdy;
        r_rob[w_free_idx]    <= dsp_ROB_idx;
`ifdef RS_OLDEST_FIRST_EN
        r_age[w_free_idx]    <= '0;
`endif
      end
    end
  end

endmodule
`default_nettype wire
